adder_operand_sequencer: RTL and testbench

ADDER_OPERAND_SEQUENCER -- requirements
Module: adder_operand_sequencer

---
 rtl/adder_operand_sequencer.sv | 144 ++++++++++++++
 tb/tb_adder_operand_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/adder_operand_sequencer.sv
// adder_operand_sequencer: feeds a wide add/subtract through an external
// WIDTH-bit adder one slice per cycle, rippling the carry through a
// register and assembling the full-width result for a valid/ready consumer.
module adder_operand_sequencer #(
  parameter int WIDTH  = 32,
  parameter int CHUNKS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*CHUNKS-1:0]   in_a,
  input  logic [WIDTH*CHUNKS-1:0]   in_b,
  input  logic                      in_sub,
  output logic [WIDTH-1:0]          add_a,
  output logic [WIDTH-1:0]          add_b,
  output logic                      add_c0,
  input  logic [WIDTH:0]            add_s,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*CHUNKS-1:0]   out_sum,
  output logic                      out_cout,
  output logic                      out_ovf
);

  localparam int TOT = WIDTH * CHUNKS;
  // Counter must be able to represent CHUNKS so it never wraps mid-operation.
  localparam int CW  = $clog2(CHUNKS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              carry_q;
  logic              sub_q;
  logic [TOT-1:0]    a_q;
  logic [TOT-1:0]    b_q;     // already inverted for subtract
  logic [TOT-1:0]    sum_q;
  logic              cout_q;
  logic              ovf_q;
  logic              in_ready_q;
  logic              out_valid_q;

  logic              last_slice;
  logic [WIDTH-1:0]  a_sl [CHUNKS];
  logic [WIDTH-1:0]  b_sl [CHUNKS];

  // Split the latched operands into per-slice views.
  for (genvar gi = 0; gi < CHUNKS; gi++) begin : g_slice
    assign a_sl[gi] = a_q[gi*WIDTH +: WIDTH];
    assign b_sl[gi] = b_q[gi*WIDTH +: WIDTH];
  end

  assign last_slice = (cnt_q == CW'(CHUNKS - 1));

  // Drive the current slice and carry-in to the adder; quiet outside RUN.
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_c0 = 1'b0;
    if (state_q == RUN) begin
      for (int k = 0; k < CHUNKS; k++) begin
        if (cnt_q == CW'(k)) begin
          add_a = a_sl[k];
          add_b = b_sl[k];
        end
      end
      // Slice 0 takes the subtract "+1"; later slices take the ripple carry.
      add_c0 = (cnt_q == '0) ? sub_q : carry_q;
    end
  end

  // Sequencer FSM: accept operands, step through slices, hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_sub ? ~in_b : in_b;
            sub_q      <= in_sub;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < CHUNKS; k++) begin
            if (cnt_q == CW'(k)) begin
              sum_q[k*WIDTH +: WIDTH] <= add_s[WIDTH-1:0];
            end
          end
          carry_q <= add_s[WIDTH];
          cnt_q   <= cnt_q + CW'(1);
          if (last_slice) begin
            cout_q      <= add_s[WIDTH];
            // Signed overflow: operand signs agree but result sign differs.
            ovf_q       <= (a_q[TOT-1] == b_q[TOT-1]) &&
                           (add_s[WIDTH-1] != a_q[TOT-1]);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // Return to IDLE only; a new operand is accepted a cycle later.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Directed bench for adder_operand_sequencer (WIDTH=8, CHUNKS=4) with an
// ideal combinational adder attached to the add_* port.
module tb_adder_operand_sequencer;

  localparam int W = 8;
  localparam int C = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W*C-1:0]  in_a;
  logic [W*C-1:0]  in_b;
  logic            in_sub;
  logic [W-1:0]    add_a;
  logic [W-1:0]    add_b;
  logic            add_c0;
  logic [W:0]      add_s;
  logic            out_valid;
  logic            out_ready;
  logic [W*C-1:0]  out_sum;
  logic            out_cout;
  logic            out_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign add_s = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_c0};

  adder_operand_sequencer #(.WIDTH(W), .CHUNKS(C)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_c0(add_c0), .add_s(add_s),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction; ec0 holds the expected carry-in per slice (bit k).
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [31:0] esum, input logic ecout,
                       input logic eovf, input logic [3:0] ec0, input logic [7:0] eb0,
                       input int hold);
    logic [31:0] beff;
    beff = sub ? ~b : b;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < C; k++) begin
      check($sformatf("%s c0[%0d]", tag, k), {31'd0, add_c0}, {31'd0, ec0[k]});
      check($sformatf("%s add_a[%0d]", tag, k), {24'd0, add_a}, {24'd0, a[k*8 +: 8]});
      check($sformatf("%s add_b[%0d]", tag, k), {24'd0, add_b}, {24'd0, beff[k*8 +: 8]});
      check($sformatf("%s run_valid[%0d]", tag, k), {31'd0, out_valid}, 32'd0);
      check($sformatf("%s run_ready[%0d]", tag, k), {31'd0, in_ready}, 32'd0);
      if (k == 0) check($sformatf("%s add_b0", tag), {24'd0, add_b}, {24'd0, eb0});
      @(negedge clk);
    end
    check($sformatf("%s out_valid", tag), {31'd0, out_valid}, 32'd1);
    check($sformatf("%s idle_add_a", tag), {24'd0, add_a}, 32'd0);
    check($sformatf("%s sum", tag), out_sum, esum);
    check($sformatf("%s cout", tag), {31'd0, out_cout}, {31'd0, ecout});
    check($sformatf("%s ovf", tag), {31'd0, out_ovf}, {31'd0, eovf});
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_a = 32'h11111111; in_b = 32'h22222222; in_sub = 1'b0;
      @(negedge clk);
      check($sformatf("%s hold_sum[%0d]", tag, h), out_sum, esum);
      check($sformatf("%s hold_ovf[%0d]", tag, h), {31'd0, out_ovf}, {31'd0, eovf});
      check($sformatf("%s hold_valid[%0d]", tag, h), {31'd0, out_valid}, 32'd1);
      check($sformatf("%s hold_ready[%0d]", tag, h), {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("%s post_valid", tag), {31'd0, out_valid}, 32'd0);
    check($sformatf("%s post_ready", tag), {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_sum", out_sum, 32'd0);
    check("rst add_a", {24'd0, add_a}, 32'd0);
    rst = 1'b0;

    do_op("add_ff_1",  32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 4'b0010, 8'h01, 0);
    do_op("add_wrap",  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 4'b1110, 8'h01, 0);
    do_op("sub_5_7",   32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 4'b0001, 8'hF8, 0);
    do_op("add_ovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 4'b1110, 8'h01, 5);

    // Abort during slice 2; in_valid asserted alongside rst must be ignored.
    in_a = 32'h12345678; in_b = 32'h00000001; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort slice2 c0", {31'd0, add_c0}, 32'd0);
    check("abort slice2 add_a", {24'd0, add_a}, 32'h34);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("abort in_ready", {31'd0, in_ready}, 32'd1);
    check("abort out_valid", {31'd0, out_valid}, 32'd0);
    check("abort out_sum", out_sum, 32'd0);
    check("abort out_cout", {31'd0, out_cout}, 32'd0);
    check("abort out_ovf", {31'd0, out_ovf}, 32'd0);
    check("abort add_a", {24'd0, add_a}, 32'd0);
    check("abort add_b", {24'd0, add_b}, 32'd0);
    check("abort add_c0", {31'd0, add_c0}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("abort quiet[%0d]", i), {31'd0, out_valid}, 32'd0);
    end

    do_op("add_1_2",   32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0, 4'b0000, 8'h02, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
